apb_gpio_arbiter: RTL and testbench
===================================

APB_GPIO_ARBITER -- requirements
Module: apb_gpio_arbiter

Interface
REQ-001 Parameter ADDR_GPIO, default 32'h0000_0000, base address of the shared GPIO slave.
REQ-002 iPCLK  input  1  single clock; all state updates on rising edge.
REQ-003 iPRESETn  input  1  reset, synchronous and active-low.
REQ-004 iREQ0 / iREQ1  input  1 each  requester i asks for one APB transfer; held high with command stable until oACKi.
REQ-005 iWR0 / iWR1  input  1 each  1 = write, 0 = read.
REQ-006 iOFF0 / iOFF1  input  4 each  register offset: 0x0 DATA_RO, 0x4 DATA, 0x8 DIRM, 0xC OEN.
REQ-007 iWDATA0 / iWDATA1  input  32 each  write data.
REQ-008 oACK0 / oACK1  output  1 each  one-cycle completion pulse to requester i.
REQ-009 oERR  output  1  valid with oACKi; 1 = command rejected.
REQ-010 oRDATA  output  32  read data; valid with oACKi for a read.
REQ-011 oPSEL, oPENABLE, oPWRITE  output  1 each  APB master controls.
REQ-012 oPADDR  output  32  APB address; oPWDATA  output  32  APB write data.
REQ-013 iPRDATA  input  32  APB read data from the GPIO slave.

Function
REQ-014 The FSM SHALL have three states: IDLE, SETUP and ACCESS. All APB outputs SHALL be registered.
REQ-015 In IDLE, with any iREQi high and a valid offset, the block SHALL grant one requester and latch its WR, OFF and WDATA. Next state is SETUP: oPSEL=1, oPENABLE=0.
REQ-016 SETUP SHALL always advance to ACCESS after one cycle: oPSEL=1, oPENABLE=1, command held stable.
REQ-017 ACCESS SHALL always return to IDLE. On that edge the block SHALL:
 - pulse oACK of the granted requester;
 - drive oERR=0;
 - for a read, load oRDATA from iPRDATA.
REQ-018 Latency: request seen in IDLE at edge N -> oPSEL at N+1, oPENABLE at N+2, oACK at N+3. Throughput is one transfer per 3 cycles minimum.
REQ-019 oPADDR SHALL be ADDR_GPIO with bits [3:0] replaced by the latched OFF. oPWDATA SHALL be the latched WDATA.
REQ-020 oPWRITE SHALL be 1 only in SETUP/ACCESS of a write, and 0 otherwise. oPENABLE and oPSEL SHALL be 0 in IDLE, because the slave writes on PENABLE&PWRITE without qualifying PSEL.
REQ-021 Arbitration SHALL be two-way round-robin:
 - simultaneous requests go to the requester not granted last;
 - the priority pointer updates only when a grant is issued.
REQ-022 A misaligned offset (OFF[1:0]!=0) SHALL NOT generate an APB transfer. Instead, in the cycle after it is seen in IDLE, the block SHALL pulse oACKi with oERR=1. This rejection SHALL consume the arbitration turn like a grant.
REQ-023 A write to offset 0x0 (read-only) SHALL be issued normally with oERR=0; the slave discards it.
REQ-024 A read returns the slave's read value regardless of offset; the block SHALL NOT alter it.
REQ-025 Requests arriving during SETUP/ACCESS SHALL wait. A requester SHALL NOT be re-granted in the cycle its oACK is high.
REQ-026 oACK0 and oACK1 SHALL never be high together.
REQ-027 oRDATA SHALL hold its last value except when loaded by a read completion.

Reset
REQ-028 While iPRESETn=0 at a clock edge, state SHALL go to IDLE and the following SHALL be 0:
 - oPSEL, oPENABLE, oPWRITE, oACK0, oACK1, oERR;
 - oPADDR, oPWDATA, oRDATA.
REQ-029 After reset, the round-robin pointer SHALL favour requester 0.
REQ-030 A reset during SETUP/ACCESS SHALL abort the transfer with no oACK. The requester re-requests after reset.

Structure
REQ-031 Package apb_gpio_pkg SHALL hold:
 - the four offset constants;
 - the FSM state encoding;
 - the APB data width (32).
REQ-032 A sub-module rr_arb2 (2-input round-robin arbiter: req[1:0], advance, gnt[1:0]) SHALL be instantiated once. All other logic stays in apb_gpio_arbiter.

Verification
REQ-033 Reset, then iREQ0=1, iWR0=1, iOFF0=0x8, iWDATA0=0xFF -> oPSEL=1 at N+1; oPENABLE=1, oPADDR=0x8, oPWRITE=1 at N+2; oACK0=1, oERR=0 at N+3.
REQ-034 iREQ1 read, OFF=0x0, iPRDATA=0x0000_00A5 during ACCESS -> oACK1=1 with oRDATA=0x0000_00A5 and oPWRITE=0 throughout.
REQ-035 iREQ0 and iREQ1 raised together, both held to completion -> grants 0, then 1; each oACK exactly once; oACK0 and oACK1 never overlap.
REQ-036 iREQ0 with iOFF0=0x6 -> no oPSEL pulse; oACK0=1, oERR=1 one cycle later.
REQ-037 iPRESETn=0 asserted in the ACCESS cycle -> next cycle all outputs 0, no oACK; a subsequent dual request grants requester 0 first.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// rtl/apb_gpio_pkg.sv - shared constants and types for the APB GPIO arbiter
package apb_gpio_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OFF_DATA_RO = 4'h0;
  localparam logic [3:0] OFF_DATA    = 4'h4;
  localparam logic [3:0] OFF_DIRM    = 4'h8;
  localparam logic [3:0] OFF_OEN     = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Registers are word-spaced, so only the two low offset bits decide alignment.
  function automatic logic off_aligned(input logic [1:0] off_lo);
    return (off_lo == 2'b00);
  endfunction

endpackage

// File: rtl/apb_gpio_arbiter_rr_arb2.sv
// rtl/apb_gpio_arbiter_rr_arb2.sv - two-input round-robin arbiter
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio=0 favours requester 0 on a tie, prio=1 favours requester 1.
  logic prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prio <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// rtl/apb_gpio_arbiter.sv - shares one APB GPIO slave between two requesters
module apb_gpio_arbiter
  import apb_gpio_pkg::*;
#(
  parameter logic [31:0] ADDR_GPIO = 32'h0000_0000
) (
  input  logic              iPCLK,
  input  logic              iPRESETn,
  input  logic              iREQ0,
  input  logic              iREQ1,
  input  logic              iWR0,
  input  logic              iWR1,
  input  logic [3:0]        iOFF0,
  input  logic [3:0]        iOFF1,
  input  logic [DATA_W-1:0] iWDATA0,
  input  logic [DATA_W-1:0] iWDATA1,
  output logic              oACK0,
  output logic              oACK1,
  output logic              oERR,
  output logic [DATA_W-1:0] oRDATA,
  output logic              oPSEL,
  output logic              oPENABLE,
  output logic              oPWRITE,
  output logic [31:0]       oPADDR,
  output logic [DATA_W-1:0] oPWDATA,
  input  logic [DATA_W-1:0] iPRDATA
);

  apb_state_t        state;
  logic              gnt_id;
  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  logic              advance;
  logic              sel;
  logic              sel_wr;
  logic [3:0]        sel_off;
  logic [DATA_W-1:0] sel_wdata;

  // A requester whose ack is high this cycle is still holding iREQ; mask it.
  assign req_vec = {iREQ1 & ~oACK1, iREQ0 & ~oACK0};
  assign advance = (state == ST_IDLE) && (req_vec != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk     (iPCLK),
    .resetn  (iPRESETn),
    .req     (req_vec),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    sel       = gnt[1];
    sel_wr    = iWR0;
    sel_off   = iOFF0;
    sel_wdata = iWDATA0;
    if (sel) begin
      sel_wr    = iWR1;
      sel_off   = iOFF1;
      sel_wdata = iWDATA1;
    end
  end

  always_ff @(posedge iPCLK) begin
    if (!iPRESETn) begin
      state    <= ST_IDLE;
      gnt_id   <= 1'b0;
      oPSEL    <= 1'b0;
      oPENABLE <= 1'b0;
      oPWRITE  <= 1'b0;
      oPADDR   <= '0;
      oPWDATA  <= '0;
      oACK0    <= 1'b0;
      oACK1    <= 1'b0;
      oERR     <= 1'b0;
      oRDATA   <= '0;
    end else begin
      oACK0 <= 1'b0;
      oACK1 <= 1'b0;
      oERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (advance) begin
            if (off_aligned(sel_off[1:0])) begin
              state   <= ST_SETUP;
              gnt_id  <= sel;
              oPSEL   <= 1'b1;
              oPWRITE <= sel_wr;
              oPADDR  <= {ADDR_GPIO[31:4], sel_off};
              oPWDATA <= sel_wdata;
            end else begin
              // Misaligned: reject without touching the bus.
              oACK0 <= ~sel;
              oACK1 <= sel;
              oERR  <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          oPENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          state    <= ST_IDLE;
          oPSEL    <= 1'b0;
          oPENABLE <= 1'b0;
          oPWRITE  <= 1'b0;
          oACK0    <= ~gnt_id;
          oACK1    <= gnt_id;
          if (!oPWRITE) begin
            oRDATA <= iPRDATA;
          end
        end
        default: begin
          state    <= ST_IDLE;
          oPSEL    <= 1'b0;
          oPENABLE <= 1'b0;
          oPWRITE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// tb/tb_apb_gpio_arbiter.sv - directed scoreboard bench for apb_gpio_arbiter
module tb_apb_gpio_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0, req1, wr0, wr1;
  logic [3:0]  off0, off1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err;
  logic [31:0] rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] last_ack;
  logic [1:0] done;

  always #5 clk = ~clk;

  apb_gpio_arbiter #(.ADDR_GPIO(32'h0000_0000)) dut (
    .iPCLK    (clk),
    .iPRESETn (resetn),
    .iREQ0    (req0),
    .iREQ1    (req1),
    .iWR0     (wr0),
    .iWR1     (wr1),
    .iOFF0    (off0),
    .iOFF1    (off1),
    .iWDATA0  (wdata0),
    .iWDATA1  (wdata1),
    .oACK0    (ack0),
    .oACK1    (ack1),
    .oERR     (err),
    .oRDATA   (rdata),
    .oPSEL    (psel),
    .oPENABLE (penable),
    .oPWRITE  (pwrite),
    .oPADDR   (paddr),
    .oPWDATA  (pwdata),
    .iPRDATA  (prdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic e, input logic rd, input logic [31:0] d);
    exp_t x;
    x.ack = a; x.err = e; x.rd = rd; x.rdata = d;
    sb.push_back(x);
  endtask

  // One clock; any ack seen afterwards is matched against the scoreboard head.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    @(negedge clk);
    last_ack = {ack1, ack0};
    if (last_ack != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, last_ack}, 32'd0);
      end else begin
        x = sb.pop_front();
        check("ack_port", {30'd0, last_ack}, {30'd0, x.ack});
        check("ack_err", {31'd0, err}, {31'd0, x.err});
        if (x.rd) check("ack_rdata", rdata, x.rdata);
      end
    end
  endtask

  task automatic run_dual(input string tag);
    done = 2'b00;
    for (int i = 0; i < 20 && done != 2'b11; i++) begin
      tick();
      if (last_ack[0]) begin req0 = 1'b0; done[0] = 1'b1; end
      if (last_ack[1]) begin req1 = 1'b0; done[1] = 1'b1; end
    end
    check({tag, "_both_done"}, {30'd0, done}, 32'd3);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, psel, penable, pwrite, ack0, ack1, err}, 32'd0);
    check({tag, "_paddr"}, paddr, 32'd0);
    check({tag, "_pwdata"}, pwdata, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    off0 = 4'h0; off1 = 4'h0; wdata0 = '0; wdata1 = '0; prdata = '0;
    @(negedge clk);
    tick(); tick();
    check_all_zero("reset");
    resetn = 1'b1;
    tick();

    // Single write, cycle-by-cycle latency
    req0 = 1'b1; wr0 = 1'b1; off0 = 4'h8; wdata0 = 32'h0000_00FF;
    push(2'b01, 1'b0, 1'b0, 32'd0);
    tick();
    check("wr_setup_psel", {31'd0, psel}, 32'd1);
    check("wr_setup_penable", {31'd0, penable}, 32'd0);
    tick();
    check("wr_access_penable", {31'd0, penable}, 32'd1);
    check("wr_access_paddr", paddr, 32'h0000_0008);
    check("wr_access_pwrite", {31'd0, pwrite}, 32'd1);
    check("wr_access_pwdata", pwdata, 32'h0000_00FF);
    tick();
    check("wr_ack0", {31'd0, ack0}, 32'd1);
    check("wr_idle_psel", {30'd0, psel, penable}, 32'd0);
    req0 = 1'b0;
    tick();

    // Read from requester 1
    req1 = 1'b1; wr1 = 1'b0; off1 = 4'h0; prdata = 32'h0000_00A5;
    push(2'b10, 1'b0, 1'b1, 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_pwrite_low", {31'd0, pwrite}, 32'd0);
    end
    check("rd_ack1", {31'd0, ack1}, 32'd1);
    req1 = 1'b0;
    tick();

    // Simultaneous writes: pointer favours 0 after last grant to 1
    req0 = 1'b1; wr0 = 1'b1; off0 = 4'h4; wdata0 = 32'h1111_1111;
    req1 = 1'b1; wr1 = 1'b1; off1 = 4'hC; wdata1 = 32'h2222_2222;
    push(2'b01, 1'b0, 1'b0, 32'd0);
    push(2'b10, 1'b0, 1'b0, 32'd0);
    run_dual("dual_wr");
    tick(); tick();
    check("rdata_held", rdata, 32'h0000_00A5);

    // Misaligned offset: rejected without a bus cycle
    req0 = 1'b1; wr0 = 1'b0; off0 = 4'h6;
    push(2'b01, 1'b1, 1'b0, 32'd0);
    tick();
    check("misaligned_no_psel", {31'd0, psel}, 32'd0);
    check("misaligned_ack0", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    tick();

    // Rejection consumed the turn: requester 1 wins the next tie
    req0 = 1'b1; wr0 = 1'b0; off0 = 4'h4;
    req1 = 1'b1; wr1 = 1'b0; off1 = 4'h8; prdata = 32'h5A5A_0F0F;
    push(2'b10, 1'b0, 1'b1, 32'h5A5A_0F0F);
    push(2'b01, 1'b0, 1'b1, 32'h5A5A_0F0F);
    run_dual("rr_after_err");
    tick();

    // Write to the read-only register completes without error
    req1 = 1'b1; wr1 = 1'b1; off1 = 4'h0; wdata1 = 32'hDEAD_BEEF;
    push(2'b10, 1'b0, 1'b0, 32'd0);
    tick();
    check("ro_wr_paddr", paddr, 32'h0000_0000);
    tick(); tick();
    check("ro_wr_ack1", {31'd0, ack1}, 32'd1);
    req1 = 1'b0;
    tick();

    // Reset during ACCESS aborts with no ack
    req1 = 1'b1; wr1 = 1'b0; off1 = 4'h4;
    tick(); tick();
    check("abort_in_access", {30'd0, psel, penable}, 32'd3);
    resetn = 1'b0;
    tick();
    check_all_zero("abort");
    resetn = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; off0 = 4'hC; prdata = 32'h0000_1234;
    push(2'b01, 1'b0, 1'b1, 32'h0000_1234);
    push(2'b10, 1'b0, 1'b1, 32'h0000_1234);
    run_dual("post_reset");
    tick(); tick();
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
